// File: rtl/byte_arb_mux_n_to_1.sv
// Registered N-to-1 selector with valid/ready handshakes.
// Fixed-select or round-robin choice feeds a single output stage.
module byte_arb_mux_n_to_1 #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int SELW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_ch,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int NSEL = 1 << SELW;

  logic [SELW-1:0]  rr_ptr;
  logic [SELW-1:0]  rr_next;
  logic [NSEL-1:0]  valid_ext;
  logic [WIDTH-1:0] data_arr [NSEL];
  logic             load_en;
  logic             sel_ok;
  logic             hi_hit, lo_hit;
  logic [SELW-1:0]  hi_idx, lo_idx;
  logic [SELW-1:0]  chosen;
  logic             grant;
  logic             xfer;

  assign valid_ext = NSEL'(in_valid);
  assign load_en   = !out_valid || out_ready;
  assign sel_ok    = {1'b0, sel} < (SELW+1)'(NCH);

  always_comb begin
    for (int i = 0; i < NSEL; i++) data_arr[i] = '0;
    for (int i = 0; i < NCH; i++)
      data_arr[i] = in_data[i*WIDTH +: WIDTH];
  end

  // Lowest valid index at or above rr_ptr wins, else lowest overall.
  always_comb begin
    hi_hit = 1'b0;
    lo_hit = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (in_valid[i]) begin
        lo_hit = 1'b1;
        lo_idx = SELW'(i);
        if (SELW'(i) >= rr_ptr) begin
          hi_hit = 1'b1;
          hi_idx = SELW'(i);
        end
      end
    end
  end

  always_comb begin
    chosen = sel;
    grant  = sel_ok && valid_ext[sel];
    if (mode) begin
      chosen = hi_hit ? hi_idx : lo_idx;
      grant  = lo_hit;
    end
  end

  assign xfer    = load_en && grant;
  assign rr_next = (chosen == SELW'(NCH - 1)) ? '0 : chosen + 1'b1;

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < NCH; i++)
      in_ready[i] = !rst && xfer && (chosen == SELW'(i));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      rr_ptr    <= '0;
    end else if (load_en) begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= data_arr[chosen];
        out_ch    <= chosen;
        if (mode) rr_ptr <= rr_next;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_byte_arb_mux_n_to_1.sv
// Directed bench for byte_arb_mux_n_to_1 (NCH=4 and NCH=3 builds).
module tb_byte_arb_mux_n_to_1;

  localparam int W = 8;
  localparam int N = 4;
  localparam int S = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic           mode;
  logic [S-1:0]   sel;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [W-1:0]   out_data;
  logic [S-1:0]   out_ch;
  logic           out_valid;
  logic           out_ready;

  logic           mode3;
  logic [S-1:0]   sel3;
  logic [3*W-1:0] in_data3;
  logic [2:0]     in_valid3;
  logic [2:0]     in_ready3;
  logic [W-1:0]   out_data3;
  logic [S-1:0]   out_ch3;
  logic           out_valid3;
  logic           out_ready3;

  byte_arb_mux_n_to_1 #(.WIDTH(W), .NCH(N), .SELW(S)) u4 (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  byte_arb_mux_n_to_1 #(.WIDTH(W), .NCH(3), .SELW(S)) u3 (
    .clk(clk), .rst(rst), .mode(mode3), .sel(sel3),
    .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .out_data(out_data3), .out_ch(out_ch3), .out_valid(out_valid3),
    .out_ready(out_ready3)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] dat [4];
  int fx [4];
  int rr [5];
  int sp [4];

  initial begin
    dat = '{8'hFF, 8'h00, 8'hAA, 8'h0F};
    fx  = '{0, 2, 1, 3};
    rr  = '{0, 1, 2, 3, 0};
    sp  = '{1, 3, 1, 3};

    in_data    = {8'h0F, 8'hAA, 8'h00, 8'hFF};
    in_valid   = 4'hF;
    mode       = 1'b0;
    sel        = '0;
    out_ready  = 1'b1;
    in_data3   = {8'hAA, 8'h00, 8'hFF};
    in_valid3  = 3'b111;
    mode3      = 1'b0;
    sel3       = 2'd3;
    out_ready3 = 1'b1;

    #1 rst = 1'b1;
    #2;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'h00);
    check("rst_ch", 32'(out_ch), 32'd0);
    check("rst_ready", 32'(in_ready), 32'h0);
    tick();
    rst = 1'b0;
    #1;

    // fixed select
    for (int k = 0; k < 4; k++) begin
      sel = S'(fx[k]);
      #1;
      check("fix_ready", 32'(in_ready), 32'(1 << fx[k]));
      tick();
      check("fix_data", 32'(out_data), 32'(dat[fx[k]]));
      check("fix_ch", 32'(out_ch), 32'(fx[k]));
      check("fix_valid", 32'(out_valid), 32'd1);
    end

    // round robin, all valid
    mode = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("rr_ready", 32'(in_ready), 32'(1 << rr[k]));
      tick();
      check("rr_ch", 32'(out_ch), 32'(rr[k]));
      check("rr_data", 32'(out_data), 32'(dat[rr[k]]));
    end

    // sparse round robin
    in_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("sp_ready", 32'(in_ready), 32'(1 << sp[k]));
      tick();
      check("sp_ch", 32'(out_ch), 32'(sp[k]));
    end
    in_valid = 4'b1000;
    for (int k = 0; k < 2; k++) begin
      #1;
      check("wrap_ready", 32'(in_ready), 32'h8);
      tick();
      check("wrap_ch", 32'(out_ch), 32'd3);
    end

    // backpressure
    mode     = 1'b0;
    in_valid = 4'hF;
    sel      = 2'd2;
    tick();
    check("bp_load", 32'(out_data), 32'hAA);
    out_ready = 1'b0;
    sel       = 2'd0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_ready", 32'(in_ready), 32'h0);
      tick();
      check("bp_hold", 32'(out_data), 32'hAA);
      check("bp_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    #1;
    check("bp_rel_ready", 32'(in_ready), 32'h1);
    tick();
    check("bp_next", 32'(out_data), 32'hFF);
    check("bp_nobubble", 32'(out_valid), 32'd1);

    // invalid chosen channel
    sel      = 2'd2;
    in_valid = 4'b1011;
    #1;
    check("idle_ready", 32'(in_ready), 32'h0);
    tick();
    check("idle_valid", 32'(out_valid), 32'd0);
    check("idle_data", 32'(out_data), 32'hFF);
    check("idle_ch", 32'(out_ch), 32'd0);

    // out-of-range select on NCH=3
    check("n3_ready_oor", 32'(in_ready3), 32'h0);
    check("n3_valid_oor", 32'(out_valid3), 32'd0);
    sel3 = 2'd2;
    #1;
    check("n3_ready2", 32'(in_ready3), 32'h4);
    tick();
    check("n3_data2", 32'(out_data3), 32'hAA);
    check("n3_ch2", 32'(out_ch3), 32'd2);
    sel3 = 2'd3;
    #1;
    check("n3_ready_oor2", 32'(in_ready3), 32'h0);
    tick();
    check("n3_drop", 32'(out_valid3), 32'd0);

    // reset mid-stream
    mode     = 1'b1;
    in_valid = 4'hF;
    tick();
    tick();
    tick();
    check("pre_rst_data", 32'(out_data), 32'hAA);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_data", 32'(out_data), 32'h00);
    check("mid_rst_ch", 32'(out_ch), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'h0);
    #1 rst = 1'b0;
    #1;
    check("post_rst_ready", 32'(in_ready), 32'h1);
    tick();
    check("post_rst_ch", 32'(out_ch), 32'd0);
    check("post_rst_data", 32'(out_data), 32'hFF);
    check("post_rst_valid", 32'(out_valid), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
